// File: rtl/pipelined_block_accumulator.sv
// pipelined_block_accumulator
//
// This block reduces a stream of vector beats into one signed sum per block.
// Each beat of ELEMS_COUNT signed elements is summed exactly by a registered
// adder tree. An accumulator then adds consecutive beat sums until a beat
// flagged last arrives, and emits one block result.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset; drops all in-flight beats
//   sat_mode_i   per-beat mode: 0 = wrap on overflow, 1 = saturate
//   in_valid_i   beat valid
//   in_ready_o   beat can be accepted this cycle
//   in_last_i    beat closes the current block
//   in_vec_i     ELEMS_COUNT signed elements of IN_WIDTH bits
//   out_valid_o  block result valid
//   out_ready_i  consumer takes the result
//   out_sum_o    signed block sum (ACC_WIDTH bits)
//   out_count_o  number of beats in the block, saturating
//   out_ovf_o    a signed overflow happened somewhere in the block
//
// Handshake rules, for both ports: a transfer happens on a rising edge where
// valid and ready are both 1. A producer holding valid=1 keeps its data stable
// until that transfer. The output side holds out_* steady while
// out_valid_o=1 and out_ready_i=0. The whole pipeline freezes while a result
// is waiting, so in_ready_o never depends on in_valid_i.
module pipelined_block_accumulator #(
  parameter int IN_WIDTH    = 8,
  parameter int ELEMS_COUNT = 8,
  parameter int ACC_WIDTH   = IN_WIDTH + $clog2(ELEMS_COUNT) + 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sat_mode_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        in_last_i,
  input  logic signed [IN_WIDTH-1:0]  in_vec_i [ELEMS_COUNT],
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic signed [ACC_WIDTH-1:0] out_sum_o,
  output logic        [CNT_WIDTH-1:0] out_count_o,
  output logic                        out_ovf_o
);

  localparam int TREE_DEPTH = $clog2(ELEMS_COUNT);
  localparam int TREE_WIDTH = IN_WIDTH + TREE_DEPTH;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef logic signed [TREE_WIDTH-1:0] lane_t;

  // Level 0 is the input register; level k holds ELEMS_COUNT>>k partial sums.
  // Every lane is kept at the full tree width, which is exact at every level.
  lane_t                 lvl_q  [TREE_DEPTH+1][ELEMS_COUNT];
  lane_t                 lvl_d  [TREE_DEPTH+1][ELEMS_COUNT];
  logic [TREE_DEPTH:0]   vld_q, vld_d;
  logic [TREE_DEPTH:0]   last_q, last_d;
  logic [TREE_DEPTH:0]   sat_q, sat_d;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic        [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;

  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic        [CNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                        out_ovf_q, out_ovf_d;

  logic                        en;
  lane_t                       tree_sum;
  logic signed [ACC_WIDTH:0]   tree_ext;
  logic signed [ACC_WIDTH:0]   acc_ext;
  logic signed [ACC_WIDTH:0]   nxt_sum;
  logic signed [ACC_WIDTH-1:0] res;
  logic                        ovf_now;
  logic        [CNT_WIDTH-1:0] cnt_inc;

  // The pipeline only freezes when a finished result is still waiting.
  assign en         = !(out_valid_q && !out_ready_i);
  assign in_ready_o = en && !rst_i;

  always_comb begin : tree_comb
    lvl_d  = lvl_q;
    vld_d  = vld_q;
    last_d = last_q;
    sat_d  = sat_q;
    if (en) begin
      vld_d[0]  = in_valid_i && in_ready_o;
      last_d[0] = in_last_i;
      sat_d[0]  = sat_mode_i;
      for (int i = 0; i < ELEMS_COUNT; i++) begin
        lvl_d[0][i] = TREE_WIDTH'(in_vec_i[i]);
      end
      for (int k = 1; k <= TREE_DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        last_d[k] = last_q[k-1];
        sat_d[k]  = sat_q[k-1];
        // Lanes above ELEMS_COUNT>>k are never read downstream.
        for (int j = 0; j < ELEMS_COUNT / 2; j++) begin
          lvl_d[k][j] = lvl_q[k-1][2*j] + lvl_q[k-1][2*j+1];
        end
      end
    end
  end

  always_comb begin : acc_comb
    tree_sum = lvl_q[TREE_DEPTH][0];
    tree_ext = {{(ACC_WIDTH+1-TREE_WIDTH){tree_sum[TREE_WIDTH-1]}}, tree_sum};
    acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
    nxt_sum  = acc_ext + tree_ext;
    // The sum overflows when the top two bits of the one-bit-wider sum disagree.
    ovf_now  = nxt_sum[ACC_WIDTH] ^ nxt_sum[ACC_WIDTH-1];
    if (ovf_now && sat_q[TREE_DEPTH]) begin
      res = nxt_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      res = nxt_sum[ACC_WIDTH-1:0];
    end
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q && !out_ready_i;

    if (en && vld_q[TREE_DEPTH]) begin
      if (last_q[TREE_DEPTH]) begin
        out_sum_d   = res;
        out_count_d = cnt_inc;
        out_ovf_d   = ovf_q | ovf_now;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = res;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | ovf_now;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= TREE_DEPTH; k++) begin
        for (int i = 0; i < ELEMS_COUNT; i++) begin
          lvl_q[k][i] <= '0;
        end
      end
      vld_q       <= '0;
      last_q      <= '0;
      sat_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      lvl_q       <= lvl_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      sat_q       <= sat_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_count_o = out_count_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_pipelined_block_accumulator.sv
// Bench for pipelined_block_accumulator. Two instances share one stimulus
// stream: the default 19-bit accumulator and a narrow 12-bit one, so that the
// overflow and saturation cases can be reached.
module tb_pipelined_block_accumulator;

  localparam int EW = 8;
  localparam int EC = 8;
  localparam int A0 = 19;
  localparam int A1 = 12;
  localparam int CW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_i;
  logic                 sat_mode_i;
  logic                 in_valid_i;
  logic                 in_last_i;
  logic                 out_ready_i;
  logic signed [EW-1:0] in_vec_i [EC];

  logic                 in_ready0, in_ready1;
  logic                 out_valid0, out_valid1;
  logic signed [A0-1:0] sum0;
  logic signed [A1-1:0] sum1;
  logic        [CW-1:0] cnt0, cnt1;
  logic                 ovf0, ovf1;

  pipelined_block_accumulator #(.IN_WIDTH(EW), .ELEMS_COUNT(EC), .ACC_WIDTH(A0), .CNT_WIDTH(CW)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .sat_mode_i(sat_mode_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready0), .in_last_i(in_last_i), .in_vec_i(in_vec_i),
    .out_valid_o(out_valid0), .out_ready_i(out_ready_i), .out_sum_o(sum0),
    .out_count_o(cnt0), .out_ovf_o(ovf0)
  );

  pipelined_block_accumulator #(.IN_WIDTH(EW), .ELEMS_COUNT(EC), .ACC_WIDTH(A1), .CNT_WIDTH(CW)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .sat_mode_i(sat_mode_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready1), .in_last_i(in_last_i), .in_vec_i(in_vec_i),
    .out_valid_o(out_valid1), .out_ready_i(out_ready_i), .out_sum_o(sum1),
    .out_count_o(cnt1), .out_ovf_o(ovf1)
  );

  // scoreboard
  int          checks_cnt = 0;
  int          errors_cnt = 0;
  logic [63:0] exp_sum0_q[$];
  logic [63:0] exp_sum1_q[$];
  logic [63:0] exp_cnt0_q[$];
  logic [63:0] exp_cnt1_q[$];
  logic [63:0] exp_ovf0_q[$];
  logic [63:0] exp_ovf1_q[$];
  longint      m_acc [2];
  bit          m_ovf [2];
  longint      m_cnt;
  bit          rand_on;
  int          lat;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks_cnt++;
    if (obs != exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 0;
      m_ovf[d] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Reference behaviour of one accepted beat for both accumulator widths.
  task automatic model_beat(input longint s, input bit last, input bit sat);
    longint nxt, mx, mn;
    bit     o;
    int     w;
    for (int d = 0; d < 2; d++) begin
      w   = (d == 0) ? A0 : A1;
      mx  = (longint'(1) <<< (w - 1)) - 1;
      mn  = -mx - 1;
      nxt = m_acc[d] + s;
      o   = (nxt > mx) || (nxt < mn);
      if (o) begin
        if (sat)           nxt = (nxt > mx) ? mx : mn;
        else if (nxt > mx) nxt = nxt - 2 * (mx + 1);
        else               nxt = nxt + 2 * (mx + 1);
      end
      m_ovf[d] = m_ovf[d] | o;
      m_acc[d] = nxt;
    end
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (last) begin
      exp_sum0_q.push_back(64'(m_acc[0]));
      exp_sum1_q.push_back(64'(m_acc[1]));
      exp_ovf0_q.push_back(64'(m_ovf[0]));
      exp_ovf1_q.push_back(64'(m_ovf[1]));
      exp_cnt0_q.push_back(64'(m_cnt));
      exp_cnt1_q.push_back(64'(m_cnt));
      model_clear();
    end
  endtask

  // driver tasks (entered on a falling edge, leave on a falling edge)
  task automatic fill(input int v);
    for (int i = 0; i < EC; i++) in_vec_i[i] = EW'(v);
  endtask

  task automatic send_cur(input bit last, input bit sat);
    longint s = 0;
    bit     r;
    int     n = 0;
    for (int i = 0; i < EC; i++) s += longint'(in_vec_i[i]);
    in_valid_i = 1'b1;
    in_last_i  = last;
    sat_mode_i = sat;
    forever begin
      #1 r = in_ready0;
      @(posedge clk);
      @(negedge clk);
      if (r) break;
      n++;
      if (n > 3000) begin
        chk("in_ready_timeout", n, 0);
        in_valid_i = 1'b0;
        return;
      end
    end
    in_valid_i = 1'b0;
    model_beat(s, last, sat);
  endtask

  task automatic wait_both(input string tag, input longint s0, input longint o0,
                           input longint s1, input longint o1, input longint c);
    int i = 0;
    while (!out_valid0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_seen"}, longint'(out_valid0), 1);
    chk({tag, "_sum0"}, longint'(sum0), s0);
    chk({tag, "_cnt0"}, longint'(cnt0), c);
    chk({tag, "_ovf0"}, longint'(ovf0), o0);
    chk({tag, "_sum1"}, longint'(sum1), s1);
    chk({tag, "_cnt1"}, longint'(cnt1), c);
    chk({tag, "_ovf1"}, longint'(ovf1), o1);
  endtask

  task automatic drain(input string tag);
    int i = 0;
    while ((exp_cnt0_q.size() != 0 || exp_cnt1_q.size() != 0) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_left0"}, longint'(exp_cnt0_q.size()), 0);
    chk({tag, "_left1"}, longint'(exp_cnt1_q.size()), 0);
  endtask

  initial begin
    rst_i       = 1'b1;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    sat_mode_i  = 1'b0;
    rand_on     = 1'b0;
    fill(0);
    model_clear();

    // Result monitor: a result seen with ready high retires on the next edge.
    fork
      forever begin
        @(negedge clk);
        #2;
        if (!rst_i && out_ready_i) begin
          if (out_valid0) begin
            if (exp_cnt0_q.size() == 0) chk("unexpected_result0", 1, 0);
            else begin
              chk("mon_sum0", longint'(sum0), longint'(exp_sum0_q.pop_front()));
              chk("mon_cnt0", longint'(cnt0), longint'(exp_cnt0_q.pop_front()));
              chk("mon_ovf0", longint'(ovf0), longint'(exp_ovf0_q.pop_front()));
            end
          end
          if (out_valid1) begin
            if (exp_cnt1_q.size() == 0) chk("unexpected_result1", 1, 0);
            else begin
              chk("mon_sum1", longint'(sum1), longint'(exp_sum1_q.pop_front()));
              chk("mon_cnt1", longint'(cnt1), longint'(exp_cnt1_q.pop_front()));
              chk("mon_ovf1", longint'(ovf1), longint'(exp_ovf1_q.pop_front()));
            end
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready0", longint'(in_ready0), 0);
    chk("rst_in_ready1", longint'(in_ready1), 0);
    chk("rst_out_valid", longint'(out_valid0), 0);
    chk("rst_sum", longint'(sum0), 0);
    chk("rst_cnt", longint'(cnt0), 0);
    chk("rst_ovf", longint'(ovf0), 0);
    rst_i = 1'b0;
    #1 chk("ready_after_rst", longint'(in_ready0), 1);
    @(negedge clk);

    // single beat of eight +1: five-cycle latency, valid for one cycle
    fill(1);
    send_cur(1'b1, 1'b0);
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    wait_both("single", 8, 0, 8, 0, 1);
    @(negedge clk);
    chk("single_valid_drop", longint'(out_valid0), 0);

    // three beats: 1016 - 1024 + 24
    fill(127);  send_cur(1'b0, 1'b0);
    fill(-128); send_cur(1'b0, 1'b0);
    fill(3);    send_cur(1'b1, 1'b0);
    wait_both("mixed", 16, 0, 16, 0, 3);

    // four beats of 1016: saturate, then wrap, on the 12-bit instance
    fill(127);
    for (int i = 0; i < 4; i++) send_cur(i == 3, 1'b1);
    wait_both("sat", 4064, 0, 2047, 1, 4);
    for (int i = 0; i < 4; i++) send_cur(i == 3, 1'b0);
    wait_both("wrap", 4064, 0, -32, 1, 4);

    // backpressure: result A stalls with block B in flight
    @(negedge clk);
    out_ready_i = 1'b0;
    fill(1); send_cur(1'b1, 1'b0);
    fill(5); send_cur(1'b0, 1'b0);
    fill(6); send_cur(1'b0, 1'b0);
    fill(7); send_cur(1'b1, 1'b0);
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_seen", longint'(out_valid0), 1);
    fill(9);
    in_valid_i = 1'b1;
    in_last_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready_low", longint'(in_ready0), 0);
      chk("bp_sum_hold", longint'(sum0), 8);
      chk("bp_cnt_hold", longint'(cnt0), 1);
      @(negedge clk);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    send_cur(1'b1, 1'b0);
    drain("bp_drain");

    // reset after two beats of a block, then a fresh single beat
    fill(4);
    send_cur(1'b0, 1'b0);
    send_cur(1'b0, 1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_clear();
    fill(2);
    send_cur(1'b1, 1'b0);
    wait_both("post_rst", 16, 0, 16, 0, 1);
    drain("post_rst_drain");

    // back-to-back single-beat blocks give results on consecutive cycles
    fill(1); send_cur(1'b1, 1'b0);
    fill(2); send_cur(1'b1, 1'b0);
    fill(3); send_cur(1'b1, 1'b0);
    wait_both("b2b_a", 8, 0, 8, 0, 1);
    @(negedge clk);
    chk("b2b_b_valid", longint'(out_valid0), 1);
    chk("b2b_b_sum", longint'(sum0), 16);
    @(negedge clk);
    chk("b2b_c_valid", longint'(out_valid0), 1);
    chk("b2b_c_sum", longint'(sum0), 24);
    drain("b2b_drain");

    // random blocks with valid/ready gaps; the last block exceeds 255 beats
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(negedge clk);
          out_ready_i = ($urandom_range(0, 3) != 0);
        end
        out_ready_i = 1'b1;
      end
      begin
        for (int b = 0; b < 6; b++) begin
          int len;
          len = (b == 5) ? 300 : int'($urandom_range(1, 20));
          for (int i = 0; i < len; i++) begin
            for (int e = 0; e < EC; e++) in_vec_i[e] = EW'($urandom_range(0, 255));
            send_cur(i == len - 1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
          end
        end
        rand_on = 1'b0;
      end
    join
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
